// File: rtl/crc_serial.sv
// crc_serial: bit-serial CRC generator built on an MSb-first Galois LFSR, parameterised for the CRC-8 family.
// Optional feature macro CRC_SERIAL_CLEAR_EN adds a synchronous clear input (priority rst > clear > enable).
module crc_serial #(
  parameter int unsigned      WIDTH   = 8,
  parameter logic [WIDTH-1:0] POLY    = 8'h07,
  parameter logic [WIDTH-1:0] INIT    = 8'h00,
  parameter bit               REF_OUT = 1'b1,
  parameter logic [WIDTH-1:0] XOR_OUT = 8'h00
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             data,
  input  logic             enable,
`ifdef CRC_SERIAL_CLEAR_EN
  input  logic             clear,
`endif
  output logic [WIDTH-1:0] crc_out
);

  function automatic logic [WIDTH-1:0] bit_reverse(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    r = {WIDTH{1'b0}};
    for (int i = 0; i < int'(WIDTH); i++) begin
      r[i] = v[int'(WIDTH)-1-i];
    end
    return r;
  endfunction

  logic [WIDTH-1:0] lfsr_r;
  logic [WIDTH-1:0] lfsr_next_s;
  logic [WIDTH-1:0] refl_s;
  logic             fb_s;
  logic             clear_s;

`ifdef CRC_SERIAL_CLEAR_EN
  assign clear_s = clear;
`else
  assign clear_s = 1'b0;
`endif

  // Next LFSR value for one message bit; only consumed when enable is high, so X on data is harmless.
  always_comb begin
    fb_s        = lfsr_r[WIDTH-1] ^ data;
    lfsr_next_s = {lfsr_r[WIDTH-2:0], 1'b0};
    if (fb_s) begin
      lfsr_next_s = {lfsr_r[WIDTH-2:0], 1'b0} ^ POLY;
    end else begin
      lfsr_next_s = {lfsr_r[WIDTH-2:0], 1'b0};
    end
  end

  // LFSR state: reset and clear both restart from INIT, otherwise advance on enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_r <= INIT;
    end else if (clear_s) begin
      lfsr_r <= INIT;
    end else if (enable) begin
      lfsr_r <= lfsr_next_s;
    end else begin
      lfsr_r <= lfsr_r;
    end
  end

  // Output shaping is pure wiring on the state so crc_out tracks the latest enabled edge.
  always_comb begin
    refl_s = lfsr_r;
    if (REF_OUT) begin
      refl_s = bit_reverse(lfsr_r);
    end else begin
      refl_s = lfsr_r;
    end
    crc_out = refl_s ^ XOR_OUT;
  end

endmodule

// File: tb/tb_crc_serial.sv
// Bench for crc_serial: ten CRC-8 variants fed "123456789", checked against a polynomial-division model.
module tb_crc_serial;

  localparam int N = 10;
  localparam logic [7:0] POLYS [0:N-1] = '{8'h07, 8'h9B, 8'hD5, 8'h1D, 8'h07, 8'h9B, 8'h07, 8'h31, 8'h1D, 8'h39};
  localparam logic [7:0] INITS [0:N-1] = '{8'h00, 8'hFF, 8'h00, 8'hFD, 8'h00, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00};
  localparam bit         REFS  [0:N-1] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  localparam logic [7:0] XORS  [0:N-1] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h55, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
  // Hand-computed check values and post-reset outputs.
  localparam logic [7:0] EXPS  [0:N-1] = '{8'hF4, 8'hDA, 8'hBC, 8'h7E, 8'hA1, 8'h25, 8'hD0, 8'hA1, 8'h97, 8'h15};
  localparam logic [7:0] POSTR [0:N-1] = '{8'h00, 8'hFF, 8'h00, 8'hFD, 8'h55, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00};
  localparam logic [7:0] MSG   [0:8]   = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

  logic clk;
  logic rst;
  logic enable;
  logic clear;
  logic data_msb;
  logic data_lsb;
  logic [7:0] crc [0:N-1];

  int checks = 0;
  int errors = 0;
  bit model_valid = 1'b0;
  bit hist_m[$];
  bit hist_l[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar i = 0; i < N; i++) begin : g_dut
    crc_serial #(
      .WIDTH(8), .POLY(POLYS[i]), .INIT(INITS[i]), .REF_OUT(REFS[i]), .XOR_OUT(XORS[i])
    ) u_dut (
      .clk(clk),
      .rst(rst),
      .data(REFS[i] ? data_lsb : data_msb),
      .enable(enable),
`ifdef CRC_SERIAL_CLEAR_EN
      .clear(clear),
`endif
      .crc_out(crc[i])
    );
  end

  // Remainder of a GF(2) polynomial (coefficients MSb first) modulo x^8 + poly.
  function automatic logic [7:0] poly_mod(input logic [7:0] poly, input bit bits[$]);
    logic [8:0] r;
    r = 9'd0;
    foreach (bits[k]) begin
      r = {r[7:0], bits[k]};
      if (r[8]) r = r ^ {1'b1, poly};
    end
    return r[7:0];
  endfunction

  // CRC = (M(x)*x^8 + INIT*x^n) mod P, then optional reversal and final XOR.
  function automatic logic [7:0] model_crc(input int idx);
    bit msg[$];
    bit dvd[$];
    logic [7:0] a, b, r, rr;
    if (REFS[idx]) msg = hist_l; else msg = hist_m;
    dvd = msg;
    for (int k = 0; k < 8; k++) dvd.push_back(1'b0);
    a = poly_mod(POLYS[idx], dvd);
    dvd.delete();
    for (int k = 7; k >= 0; k--) dvd.push_back(INITS[idx][k]);
    for (int k = 0; k < msg.size(); k++) dvd.push_back(1'b0);
    b = poly_mod(POLYS[idx], dvd);
    r = a ^ b;
    rr = r;
    if (REFS[idx]) for (int k = 0; k < 8; k++) rr[k] = r[7-k];
    return rr ^ XORS[idx];
  endfunction

  task automatic check(input string name, input int idx, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s inst%0d got %h expected %h", name, idx, got, exp);
    end
  endtask

  // Per-cycle compare: record what each edge consumed, then check all instances just after it.
  initial begin
    forever begin
      @(posedge clk);
      if (rst || clear) begin
        hist_m.delete();
        hist_l.delete();
        model_valid = 1'b1;
      end else if (enable) begin
        hist_m.push_back(data_msb);
        hist_l.push_back(data_lsb);
      end
      #1;
      if (model_valid) begin
        for (int i = 0; i < N; i++) check("model", i, crc[i], model_crc(i));
      end
    end
  end

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic stream(input int nbits, input bit gaps);
    logic [7:0] byte_v;
    for (int k = 0; k < nbits; k++) begin
      @(negedge clk);
      byte_v = MSG[(k / 8) % 9];
      enable = 1'b1;
      data_msb = byte_v[7 - (k % 8)];
      data_lsb = byte_v[k % 8];
      if (gaps) begin
        repeat ($urandom_range(0, 3)) begin
          @(negedge clk);
          enable = 1'b0;
          data_msb = ($urandom_range(0, 3) == 0) ? 1'bx : 1'($urandom_range(0, 1));
          data_lsb = ~data_msb;
        end
      end
    end
    @(negedge clk);
    enable = 1'b0;
    data_msb = 1'bx;
    data_lsb = 1'bx;
  endtask

  task automatic check_final(input string name);
    for (int i = 0; i < N; i++) begin
      check(name, i, crc[i], EXPS[i]);
      check({name, "_model_pin"}, i, model_crc(i), EXPS[i]);
    end
  endtask

  task automatic check_post(input string name);
    for (int i = 0; i < N; i++) check(name, i, crc[i], POSTR[i]);
  endtask

  initial begin
    rst = 1'b1;
    enable = 1'b0;
    clear = 1'b0;
    data_msb = 1'b0;
    data_lsb = 1'b0;

    do_reset(3);
    check_post("post_reset");
    stream(72, 1'b0);
    check_final("plain");

    do_reset(2);
    stream(72, 1'b1);
    check_final("gaps");

    do_reset(2);
    stream(20, 1'b0);
    do_reset(1);
    check_post("mid_reset");
    stream(72, 1'b0);
    check_final("after_mid_reset");

    do_reset(2);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      data_msb = c[0];
      data_lsb = c[1];
      check("reset_only", 4, crc[4], 8'h55);
    end

`ifdef CRC_SERIAL_CLEAR_EN
    do_reset(2);
    stream(30, 1'b0);
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check_post("clear");
    stream(72, 1'b0);
    check_final("after_clear");

    @(negedge clk);
    clear = 1'b1;
    enable = 1'b1;
    data_msb = 1'b1;
    data_lsb = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    enable = 1'b0;
    check_post("clear_with_enable");
    stream(72, 1'b0);
    check_final("after_clear_with_enable");
`endif

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
